// File: rtl/ac2_if.sv
// Handshake bundle between the activation accumulator (upstream), the
// weight-plane accumulator and the downstream consumer of finished dot products.
interface ac2_if #(
    parameter int unsigned M  = 16,
    parameter int unsigned Pa = 8,
    parameter int unsigned Pw = 8
);
    localparam int unsigned IW = $clog2(M) + Pa + 1;
    localparam int unsigned OW = $clog2(M) + Pa + Pw + 1;

    logic                 in_valid;
    logic signed [IW-1:0] in_ac2;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_ac2;

    // Producer of plane sums and consumer of results.
    modport master (
        output in_valid,
        output in_ac2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ac2
    );

    // The accumulator itself.
    modport slave (
        input  in_valid,
        input  in_ac2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ac2
    );
endinterface

// File: rtl/ac2_accumulator.sv
// Weight bit-plane accumulator: folds Pw activation plane sums (MSB plane first)
// into one signed dot product. Define AC2_SIGNED_WEIGHT_EN for two's-complement weights.
module ac2_accumulator #(
    parameter int unsigned M  = 16,
    parameter int unsigned Pa = 8,
    parameter int unsigned Pw = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    ac2_if.slave  bus
);
    localparam int unsigned IW = $clog2(M) + Pa + 1;
    localparam int unsigned OW = $clog2(M) + Pa + Pw + 1;
    localparam int unsigned CW = $clog2(Pw);
    localparam logic [CW-1:0] LAST_PLANE = CW'(Pw - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        plane_cnt_q, plane_cnt_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [OW-1:0] out_ac2_q, out_ac2_d;

    logic                 final_plane;
    logic                 in_ready_c;
    logic                 beat;
    logic signed [OW-1:0] in_sext;
    logic signed [OW-1:0] first_term;
    logic signed [OW-1:0] acc_next;

    assign final_plane = (state_q == ACCUM) && (plane_cnt_q == LAST_PLANE);

    // Only the final plane needs a free output slot; earlier planes keep flowing.
    assign in_ready_c = !rst && !clr && !(final_plane && out_valid_q && !bus.out_ready);
    assign beat       = bus.in_valid && in_ready_c;

    assign in_sext  = OW'(bus.in_ac2);
    assign acc_next = (acc_q <<< 1) + in_sext;

`ifdef AC2_SIGNED_WEIGHT_EN
    // MSB weight plane carries negative weight in two's complement.
    assign first_term = -in_sext;
`else
    assign first_term = in_sext;
`endif

    // State / datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            plane_cnt_q <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_ac2_q   <= '0;
        end else begin
            state_q     <= state_d;
            plane_cnt_q <= plane_cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_ac2_q   <= out_ac2_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        plane_cnt_d = plane_cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_ac2_d   = out_ac2_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            state_d     = IDLE;
            plane_cnt_d = '0;
            acc_d       = '0;
        end else if (beat) begin
            unique case (state_q)
                IDLE: begin
                    acc_d       = first_term;
                    plane_cnt_d = CW'(1);
                    state_d     = ACCUM;
                end
                ACCUM: begin
                    if (final_plane) begin
                        // A same-cycle drain is overridden so results stream without a bubble.
                        out_ac2_d   = acc_next;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        plane_cnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d       = acc_next;
                        plane_cnt_d = plane_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    plane_cnt_d = '0;
                    acc_d       = '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ac2   = out_ac2_q;

endmodule

// File: tb/tb_ac2_accumulator.sv
// Self-checking bench for ac2_accumulator (M=16, Pa=8, Pw=4): directed cases
// plus random traffic checked against a plane-list reference model.
module tb_ac2_accumulator;
    localparam int unsigned M  = 16;
    localparam int unsigned Pa = 8;
    localparam int unsigned Pw = 4;
    localparam int unsigned IW = $clog2(M) + Pa + 1;

    logic clk;
    logic rst;
    logic clr;

    ac2_if #(.M(M), .Pa(Pa), .Pw(Pw)) bus ();

    ac2_accumulator #(.M(M), .Pa(Pa), .Pw(Pw)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: planes accepted so far, plus the output buffer.
    int planes[$];
    bit exp_ov;
    int exp_out;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dot(input int p[$]);
        int s;
        s = 0;
        for (int i = 0; i < int'(Pw); i++) begin
            int w;
            w = 1 << (int'(Pw) - 1 - i);
`ifdef AC2_SIGNED_WEIGHT_EN
            if (i == 0) w = -w;
`endif
            s += p[i] * w;
        end
        return s;
    endfunction

    function automatic int signed_weight_sel(input int unsigned_val, input int signed_val);
`ifdef AC2_SIGNED_WEIGHT_EN
        return signed_val;
`else
        return unsigned_val;
`endif
    endfunction

    // One clock cycle: drive, check outputs against the model, advance both.
    task automatic step(input bit r, input bit c, input bit iv, input int d,
                        input bit ordy, output bit accepted);
        bit exp_rdy;
        @(negedge clk);
        rst           = r;
        clr           = c;
        bus.in_valid  = iv;
        bus.in_ac2    = IW'(d);
        bus.out_ready = ordy;
        #1;
        exp_rdy = !r && !c && !((planes.size() == int'(Pw) - 1) && exp_ov && !ordy);
        check("in_ready",  int'(bus.in_ready),  int'(exp_rdy));
        check("out_valid", int'(bus.out_valid), int'(exp_ov));
        check("out_ac2",   int'($signed(bus.out_ac2)), exp_out);
        accepted = iv && exp_rdy;
        @(posedge clk);
        if (r) begin
            planes.delete();
            exp_ov  = 1'b0;
            exp_out = 0;
        end else begin
            if (exp_ov && ordy) exp_ov = 1'b0;
            if (c) begin
                planes.delete();
            end else if (accepted) begin
                planes.push_back(d);
                if (planes.size() == int'(Pw)) begin
                    exp_out = dot(planes);
                    exp_ov  = 1'b1;
                    planes.delete();
                end
            end
        end
    endtask

    // Offer one plane until accepted, bounded.
    task automatic send(input int d, input bit ordy);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b0, 1'b0, 1'b1, d, ordy, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        step(1'b0, 1'b0, 1'b0, 0, ordy, acc);
    endtask

    task automatic check_result(input string tag, input int exp);
        #1;
        check(tag, int'($signed(bus.out_ac2)), exp);
    endtask

    initial begin
        bit acc;
        n_vec = 0;
        n_err = 0;
        exp_ov = 1'b0;
        exp_out = 0;
        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ac2    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and in_ready held low during reset.
        step(1'b1, 1'b0, 1'b1, 7, 1'b1, acc);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, acc);

        // 1,0,1,1 back to back.
        send(1, 1'b1); send(0, 1'b1); send(1, 1'b1); send(1, 1'b1);
        check_result("dot_1011", signed_weight_sel(11, -5));
        idle(1'b1);

        // -3 on every plane.
        send(-3, 1'b1); send(-3, 1'b1); send(-3, 1'b1); send(-3, 1'b1);
        check_result("dot_neg3", signed_weight_sel(-45, 3));

        // Result pending, next dot product stalls only on its final plane.
        step(1'b0, 1'b0, 1'b1, 100, 1'b0, acc);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0, acc);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0, acc);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0, acc);
        check("stall_final", int'(acc), 0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0, acc);
        check("stall_final2", int'(acc), 0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b1, acc);
        check("drain_final", int'(acc), 1);
        check("no_gap_valid", int'(bus.out_valid), 1);
        check_result("dot_800", signed_weight_sel(800, -800));
        idle(1'b1);

        // Abort after two planes.
        send(9, 1'b0); send(9, 1'b0);
        step(1'b0, 1'b1, 1'b1, 9, 1'b0, acc);
        send(2, 1'b0); send(2, 1'b0); send(2, 1'b0);
        check_result("clr_keep_prev", signed_weight_sel(800, -800));
        send(2, 1'b1);
        check_result("dot_2222", signed_weight_sel(30, -2));

        // Reset mid dot product with a result buffered.
        send(4, 1'b0); send(5, 1'b0); send(6, 1'b0);
        step(1'b1, 1'b0, 1'b1, 7, 1'b0, acc);
        check_result("rst_clears", 0);
        send(0, 1'b1); send(0, 1'b1); send(0, 1'b1); send(5, 1'b1);
        check_result("dot_0005", 5);

        // Streaming: three dot products, never stalled.
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b1, k - 5, 1'b1, acc);
            check("stream_accept", int'(acc), 1);
        end
        idle(1'b1);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            bit r, c, iv, ordy;
            int d;
            r    = ($urandom_range(0, 99) < 1);
            c    = ($urandom_range(0, 99) < 3);
            iv   = ($urandom_range(0, 99) < 75);
            ordy = ($urandom_range(0, 99) < 60);
            d    = int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
            step(r, c, iv, d, ordy, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
